// File: rtl/wavegen_dds_if.sv
// wavegen_dds_if: configuration write port of the wavegen_dds block.
//   cfg_we     write strobe, one cycle
//   cfg_ch     target channel (values >= NCH are ignored by the block)
//   cfg_sel    0 = freq word, 1 = phase offset, 2 = control, 3 = reserved
//   cfg_wdata  write data; control: bit0 = enable, bits2:1 = mode
// Modports: master drives the port, slave (the generator) receives it.
`timescale 1ns / 1ps

interface wavegen_dds_if #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PHASE_W = 16
);
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic               cfg_we;
  logic [CH_W-1:0]    cfg_ch;
  logic [1:0]         cfg_sel;
  logic [PHASE_W-1:0] cfg_wdata;

  modport master (output cfg_we, output cfg_ch, output cfg_sel, output cfg_wdata);
  modport slave  (input  cfg_we, input  cfg_ch, input  cfg_sel, input  cfg_wdata);
endinterface

// File: rtl/wavegen_dds.sv
// wavegen_dds: multi-channel DDS PWM waveform generator.
// Each channel owns a phase accumulator, frequency word, phase offset and mode
// (sine / triangle / saw / square). Sine samples come from one external
// single-port ROM shared by time-multiplexing inside every PWM period.
//
// Ports:
//   clk          clock
//   reset        synchronous, active-high reset
//   cfg          configuration write port (wavegen_dds_if.slave)
//   rom_addr     registered sine ROM address
//   rom_data     unsigned sine sample, valid ROM_LAT clocks after rom_addr
//   period_tick  one-cycle pulse, registered from cnt == 0
//   pwm          registered PWM outputs, one per channel
//   pwm_n        complementary outputs with dead time (WAVEGEN_DDS_COMPL_EN only)
//
// Optional feature macro: WAVEGEN_DDS_COMPL_EN adds pwm_n and DEAD clocks of
// dead time on both outputs; undefined, pwm follows the plain duty compare.
`timescale 1ns / 1ps

module wavegen_dds #(
  parameter int unsigned NCH     = 2,
  parameter int unsigned PWM_W   = 8,
  parameter int unsigned PHASE_W = 16,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned DEAD    = 2
) (
  input  logic               clk,
  input  logic               reset,
  wavegen_dds_if.slave       cfg,
  output logic [LUT_AW-1:0]  rom_addr,
  input  logic [PWM_W-1:0]   rom_data,
  output logic               period_tick,
  output logic [NCH-1:0]     pwm
`ifdef WAVEGEN_DDS_COMPL_EN
  ,
  output logic [NCH-1:0]     pwm_n
`endif
);

  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ModeSine = 2'd0;
  localparam logic [1:0] ModeTri  = 2'd1;
  localparam logic [1:0] ModeSaw  = 2'd2;
  localparam logic [1:0] ModeSqr  = 2'd3;

  // Elaboration-time sanity checks.
  if (NCH + 3 + ROM_LAT > (1 << PWM_W)) begin : g_chk_slots
    $error("wavegen_dds: NCH+3+ROM_LAT must not exceed the PWM period");
  end
  if (LUT_AW > PHASE_W || PWM_W > PHASE_W || PWM_W < 2 || PHASE_W < 3) begin : g_chk_widths
    $error("wavegen_dds: inconsistent LUT_AW / PWM_W / PHASE_W");
  end
  if (DEAD >= (1 << PWM_W)) begin : g_chk_dead
    $error("wavegen_dds: DEAD must be shorter than the PWM period");
  end

  // State.
  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] acc_q [NCH];
  logic [PHASE_W-1:0] acc_d [NCH];
  logic [PHASE_W-1:0] freq_q [NCH];
  logic [PHASE_W-1:0] freq_d [NCH];
  logic [PHASE_W-1:0] off_q [NCH];
  logic [PHASE_W-1:0] off_d [NCH];
  logic [1:0]         mode_q [NCH];
  logic [1:0]         mode_d [NCH];
  logic [PWM_W-1:0]   shadow_q [NCH];
  logic [PWM_W-1:0]   shadow_d [NCH];
  logic [PWM_W-1:0]   active_q [NCH];
  logic [PWM_W-1:0]   active_d [NCH];
  logic [NCH-1:0]     en_q, en_d;
  logic [LUT_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               tick_q, tick_d;
  logic [NCH-1:0]     pwm_q, pwm_d, pwm_raw_d;

  // Per-channel sample phase and the value each mode would capture.
  logic [PHASE_W-1:0] ph [NCH];
  logic [LUT_AW-1:0]  idx [NCH];
  logic [PWM_W-1:0]   p_w [NCH];
  logic [PWM_W-1:0]   tri_w [NCH];
  logic [PWM_W-1:0]   sample [NCH];
  logic [NCH-1:0]     unused_ph;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ph[k]        = acc_q[k] + off_q[k];
      idx[k]       = ph[k][PHASE_W-1 -: LUT_AW];
      p_w[k]       = ph[k][PHASE_W-1 -: PWM_W];
      unused_ph[k] = ^ph[k];
      tri_w[k]     = {p_w[k][PWM_W-2:0], 1'b0};
      unique case (mode_q[k])
        ModeSine: sample[k] = rom_data;
        ModeTri:  sample[k] = p_w[k][PWM_W-1] ? ~tri_w[k] : tri_w[k];
        ModeSaw:  sample[k] = p_w[k];
        ModeSqr:  sample[k] = {PWM_W{p_w[k][PWM_W-1]}};
        default:  sample[k] = '0;
      endcase
    end
  end

  // Next-state logic: config decode, accumulators, ROM sequencer, commit, compare.
  always_comb begin
    cnt_d      = cnt_q + PWM_W'(1);
    tick_d     = (cnt_q == '0);
    rom_addr_d = rom_addr_q;
    en_d       = en_q;
    freq_d     = freq_q;
    off_d      = off_q;
    mode_d     = mode_q;
    acc_d      = acc_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    pwm_raw_d  = '0;

    for (int k = 0; k < NCH; k++) begin
      if (cfg.cfg_we && (cfg.cfg_ch == CH_W'(k))) begin
        case (cfg.cfg_sel)
          2'd0: freq_d[k] = cfg.cfg_wdata;
          2'd1: off_d[k]  = cfg.cfg_wdata;
          2'd2: begin
            en_d[k]   = cfg.cfg_wdata[0];
            mode_d[k] = cfg.cfg_wdata[2:1];
          end
          default: ;
        endcase
      end

      // Uses freq_q, so a write landing on this edge waits one period.
      if (en_q[k] && (cnt_q == '0)) begin
        acc_d[k] = acc_q[k] + freq_q[k];
      end

      // ROM address is issued for every channel, whatever its mode.
      if (cnt_q == PWM_W'(k + 1)) begin
        rom_addr_d = idx[k];
      end

      if (en_q[k] && (cnt_q == PWM_W'(k + 2 + ROM_LAT))) begin
        shadow_d[k] = sample[k];
      end

      if (en_q[k] && (cnt_q == '1)) begin
        active_d[k] = shadow_q[k];
      end

      // A disabled channel is held fully cleared so re-enable starts from phase 0.
      if (!en_d[k]) begin
        acc_d[k]    = '0;
        shadow_d[k] = '0;
        active_d[k] = '0;
      end

      pwm_raw_d[k] = en_d[k] && (cnt_d < active_d[k]);
    end
  end

`ifdef WAVEGEN_DDS_COMPL_EN
  localparam int unsigned DW = (DEAD > 0) ? $clog2(DEAD + 1) : 1;

  // hi_cnt: consecutive clocks the raw compare has been high (saturating).
  // lo_cnt: consecutive clocks the delayed pwm has been low (saturating).
  logic [DW-1:0]  hi_cnt_q [NCH];
  logic [DW-1:0]  hi_cnt_d [NCH];
  logic [DW-1:0]  lo_cnt_q [NCH];
  logic [DW-1:0]  lo_cnt_d [NCH];
  logic [NCH-1:0] pwm_n_q, pwm_n_d;

  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      if (pwm_raw_d[k]) begin
        hi_cnt_d[k] = (hi_cnt_q[k] >= DW'(DEAD)) ? hi_cnt_q[k] : hi_cnt_q[k] + DW'(1);
      end else begin
        hi_cnt_d[k] = '0;
      end
      // Rising edge delayed by DEAD; pulses of DEAD clocks or less vanish.
      pwm_d[k] = pwm_raw_d[k] && (hi_cnt_q[k] >= DW'(DEAD));

      if (!pwm_d[k]) begin
        lo_cnt_d[k] = (lo_cnt_q[k] >= DW'(DEAD)) ? lo_cnt_q[k] : lo_cnt_q[k] + DW'(1);
      end else begin
        lo_cnt_d[k] = '0;
      end
      // Falls together with pwm rising, rises DEAD clocks after pwm falls.
      pwm_n_d[k] = !pwm_d[k] && (lo_cnt_q[k] >= DW'(DEAD));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_cnt_q <= '{default: '0};
      lo_cnt_q <= '{default: '0};
      pwm_n_q  <= '0;
    end else begin
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      pwm_n_q  <= pwm_n_d;
    end
  end

  assign pwm_n = pwm_n_q;
`else
  always_comb begin
    pwm_d = pwm_raw_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      acc_q      <= '{default: '0};
      freq_q     <= '{default: '0};
      off_q      <= '{default: '0};
      mode_q     <= '{default: '0};
      shadow_q   <= '{default: '0};
      active_q   <= '{default: '0};
      en_q       <= '0;
      rom_addr_q <= '0;
      tick_q     <= 1'b0;
      pwm_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      freq_q     <= freq_d;
      off_q      <= off_d;
      mode_q     <= mode_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      en_q       <= en_d;
      rom_addr_q <= rom_addr_d;
      tick_q     <= tick_d;
      pwm_q      <= pwm_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign period_tick = tick_q;
  assign pwm         = pwm_q;

endmodule

// File: tb/tb_wavegen_dds.sv
// tb_wavegen_dds: directed bench for wavegen_dds (PWM_W=4, PHASE_W=8, NCH=2).
// Tracks the period position itself after one sync on period_tick and checks
// per-period high counts and ROM addresses against hand-computed values.
`timescale 1ns / 1ps

module tb_wavegen_dds;
  localparam int unsigned NCH     = 2;
  localparam int unsigned PWM_W   = 4;
  localparam int unsigned PHASE_W = 8;
  localparam int unsigned LUT_AW  = 8;
  localparam int unsigned ROM_LAT = 1;
  localparam int          PER     = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wavegen_dds_if #(.NCH(NCH), .PHASE_W(PHASE_W)) cfg_bus ();

  logic [LUT_AW-1:0] rom_addr;
  logic [PWM_W-1:0]  rom_data;
  logic [NCH-1:0]    pwm;
  logic              period_tick;
`ifdef WAVEGEN_DDS_COMPL_EN
  logic [NCH-1:0]    pwm_n;
`endif

  wavegen_dds #(
    .NCH     (NCH),
    .PWM_W   (PWM_W),
    .PHASE_W (PHASE_W),
    .LUT_AW  (LUT_AW),
    .ROM_LAT (ROM_LAT),
    .DEAD    (2)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .cfg         (cfg_bus),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .period_tick (period_tick),
    .pwm         (pwm)
`ifdef WAVEGEN_DDS_COMPL_EN
    ,
    .pwm_n       (pwm_n)
`endif
  );

  // One-clock-latency sine ROM: sample = addr[7:4].
  always_ff @(posedge clk) rom_data <= rom_addr[7:4];

  int n_cmp = 0;
  int n_err = 0;
  int bcnt  = 0;  // bench copy of the period counter

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bcnt = (bcnt + 1) % PER;
  endtask

  task automatic goto_cnt(input int c);
    while (bcnt != c) step();
  endtask

  task automatic cfg_write(input int ch, input int sel, input int data);
    cfg_bus.cfg_we    = 1'b1;
    cfg_bus.cfg_ch    = ch[0];
    cfg_bus.cfg_sel   = sel[1:0];
    cfg_bus.cfg_wdata = data[PHASE_W-1:0];
    step();
    cfg_bus.cfg_we    = 1'b0;
  endtask

  // period_tick is high in the cycle where cnt == 1; lands on cnt == 0.
  task automatic sync_zero();
    int i;
    i = 0;
    while (!period_tick && i < 64) begin
      @(posedge clk);
      #1;
      i++;
    end
    check_eq("sync_tick", int'(period_tick), 1);
    bcnt = 1;
    goto_cnt(0);
  endtask

  // Must start at cnt == 0; counts high clocks of each channel over one period.
  task automatic measure(input int n, input int e0, input int e1);
    int h0, h1;
    h0 = 0;
    h1 = 0;
    for (int i = 0; i < PER; i++) begin
      h0 += int'(pwm[0]);
      h1 += int'(pwm[1]);
      if (bcnt == 1) check_eq($sformatf("p%0d_tick", n), int'(period_tick), 1);
      step();
    end
    check_eq($sformatf("p%0d_ch0_high", n), h0, e0);
    check_eq($sformatf("p%0d_ch1_high", n), h1, e1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    cfg_bus.cfg_we    = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_sel   = '0;
    cfg_bus.cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pwm", int'(pwm), 0);
    check_eq("rst_rom_addr", int'(rom_addr), 0);
    check_eq("rst_tick", int'(period_tick), 0);
    reset = 1'b0;
    sync_zero();

    // Saw on both channels, ch1 offset by half a turn; period n duty = n-1 / n+7.
    goto_cnt(4);
    cfg_write(0, 0, 'h10);
    cfg_write(1, 0, 'h10);
    cfg_write(1, 1, 'h80);
    cfg_write(0, 2, 5);
    cfg_write(1, 2, 5);
    goto_cnt(0);
    for (int n = 1; n <= 17; n++) begin
      measure(n, (n == 1) ? 0 : (n - 1) % 16, (n == 1) ? 0 : (n + 7) % 16);
    end

    // ch0 to sine at cnt 0; acc = 0x20 so idx0 = 0x20, idx1 = 0xA0.
    cfg_write(0, 2, 1);
    check_eq("rom_addr_cnt1", int'(rom_addr), 'h90);
    step();
    check_eq("rom_addr_cnt2", int'(rom_addr), 'h20);
    step();
    check_eq("rom_addr_cnt3", int'(rom_addr), 'hA0);
    goto_cnt(0);
    measure(19, 2, 10);

    // Square with freq 0x80 written on the accumulate edge: old freq used once.
    cfg_write(0, 0, 'h80);
    cfg_write(0, 2, 7);
    goto_cnt(0);
    measure(21, 0, 12);
    measure(22, 15, 13);
    measure(23, 0, 14);
    measure(24, 15, 15);

    // Disable ch0 while high at cnt 5 of a 15-duty period.
    step();
    goto_cnt(0);
    goto_cnt(5);
    check_eq("pre_dis_pwm0", int'(pwm[0]), 1);
    cfg_write(0, 2, 0);
    check_eq("post_dis_pwm0", int'(pwm[0]), 0);
    goto_cnt(0);
    measure(27, 0, 2);
    measure(28, 0, 3);

    // Re-enable ch0 as triangle, freq 0x20; accumulator restarts from 0.
    cfg_write(0, 0, 'h20);
    cfg_write(0, 2, 3);
    goto_cnt(0);
    measure(30, 0, 5);
    measure(31, 4, 6);
    measure(32, 8, 7);
    measure(33, 12, 8);
    measure(34, 15, 9);
    measure(35, 11, 10);

    // Reset for one cycle mid-period while both outputs are high.
    goto_cnt(5);
    check_eq("pre_rst_pwm", int'(pwm), 3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("mid_rst_pwm", int'(pwm), 0);
    check_eq("mid_rst_rom_addr", int'(rom_addr), 0);
    check_eq("mid_rst_tick0", int'(period_tick), 0);
    @(posedge clk);
    #1;
    check_eq("mid_rst_tick1", int'(period_tick), 1);
    bcnt = 1;
    goto_cnt(0);
    measure(100, 0, 0);
    measure(101, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wavegen_dds.md
Name: wavegen_dds

Overview:
- Multi-channel DDS PWM waveform generator for driving RC-filtered analogue test outputs.
- Each channel has a phase accumulator with a programmable frequency word, a phase offset and a waveform mode: sine, triangle, sawtooth or square.
- Sine samples come from one external single-port ROM. Channels share the ROM by time-multiplexing within each PWM period.
- Sits beside the ADC front end as the stimulus source; configured through a simple register write port.

Parameters:
NCH, 2, number of channels
PWM_W, 8, duty resolution; PWM period = 2^PWM_W clocks
PHASE_W, 16, phase accumulator / frequency word width
LUT_AW, 8, sine ROM address width (full wave, 2^LUT_AW entries); LUT_AW <= PHASE_W
ROM_LAT, 1, clocks from rom_addr valid to rom_data valid
DEAD, 2, dead-time clocks (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe, one cycle
cfg_ch  in  $clog2(NCH)  target channel; values >= NCH are ignored
cfg_sel  in  2  0 = freq word, 1 = phase offset, 2 = control, 3 = reserved (ignored)
cfg_wdata  in  PHASE_W  write data; control: bit0 = enable, bits2:1 = mode (0 sine, 1 triangle, 2 saw, 3 square)
rom_addr  out  LUT_AW  registered sine ROM address
rom_data  in  PWM_W  unsigned sine sample; 0 = minimum, 2^PWM_W-1 = maximum
pwm  out  NCH  registered PWM outputs
period_tick  out  1  one-cycle pulse when cnt == 0

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high.
- Reset values:
  - cnt = 0; all accumulators, frequency words, offsets, control, shadow duty and active duty = 0 (all channels disabled, mode sine).
  - pwm = 0, rom_addr = 0, period_tick = 0.
  - Reset asserted mid-operation returns to this state at the next edge; no partial period is completed.
- Period counter:
  - cnt is PWM_W bits, free-running, wraps from 2^PWM_W-1 to 0.
  - Elaboration-time check: NCH+3+ROM_LAT <= 2^PWM_W; otherwise $error.
- Accumulator: at the edge where cnt == 0, every enabled channel does acc <= acc + freq (mod 2^PHASE_W). Disabled channels hold acc = 0.
- Sample phase: ph = acc + offset (mod 2^PHASE_W).
  - idx = ph[PHASE_W-1 -: LUT_AW] (ROM index).
  - p = ph[PHASE_W-1 -: PWM_W] (phase used by non-sine modes).
- Sequencer:
  - At the edge where cnt == 1+k (k = 0..NCH-1), rom_addr <= idx of channel k. This happens even if channel k is not in sine mode.
  - At the edge where cnt == 2+k+ROM_LAT, shadow[k] is captured:
    - sine: rom_data
    - saw: p
    - triangle: p[MSB] ? ~{p[PWM_W-2:0],1'b0} : {p[PWM_W-2:0],1'b0}
    - square: p[MSB] ? all-ones : 0
- Period commit: at the edge where cnt == 2^PWM_W-1, active[k] <= shadow[k] for all channels.
- Output:
  - pwm[k] <= enable[k] && (cnt_next < active_next[k]), where cnt_next and active_next are the values taking effect at that edge.
  - Each period, pwm is high for exactly active[k] clocks, starting the clock after cnt wraps to 0.
  - duty 0 gives constant low; all-ones gives low for 1 clock per period.
- Config writes:
  - Take effect the next cycle.
  - freq changes apply at the next cnt == 0 update.
  - offset and mode changes apply at the channel's next sample slot.
  - Enable 1->0: next cycle pwm[k] = 0, acc/shadow/active cleared.
  - Enable 0->1: acc starts from 0. The first non-zero duty appears in the period after the first full sample slot and commit.
  - A write in the same cycle as the cnt == 0 accumulator update: the update uses the old freq.
- Latency: freq write to first changed pwm period = at most 2 periods.

Optional Feature:
Macro WAVEGEN_DDS_COMPL_EN.
- Defined:
  - Adds output pwm_n [NCH], the complement of pwm with DEAD clocks of dead time at each edge: pwm_n rises DEAD clocks after pwm falls, and falls at the same edge pwm rises.
  - pwm itself is delayed DEAD clocks on rising edges, so pwm and pwm_n are never simultaneously high.
  - Pulses shorter than or equal to DEAD are suppressed on the affected output.
  - pwm_n resets to 0.
- Undefined: no pwm_n port; pwm timing exactly as in Behaviour.

Test Plan:
1. PWM_W=4, PHASE_W=8, NCH=2. ch0 saw, freq=0x10, enable. From period 2 onward, expect high-counts per period of 1,2,…,15,0, repeating.
2. ch1 saw, same freq, offset=0x80, both enabled in the same cycle. Expect ch1 duty == (ch0 duty + 8) mod 16 every period.
3. ch0 sine, ROM model data = addr[7:4], ROM_LAT=1, LUT_AW=8. Expect rom_addr to change at the edges after cnt==1 (ch0) and cnt==2 (ch1). Captured duty equals the model value at idx.
4. ch0 square, freq=0x80. Expect periods alternating 15 clocks high and 0 clocks high.
5. Disable ch0 at cnt==5 while pwm=1. Expect pwm[0]=0 on the next cycle and for all following periods. Expect ch1 unaffected.
6. Assert reset for one cycle mid-period. Expect on the next cycle pwm=0, cnt=0 and period_tick=1 one clock later. Expect all channels disabled.
